// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - AES-128 key schedule sequencer with round-key register file
//
// Expands a 128-bit cipher key into round keys 0..10, one round per clock,
// using the combinational keyExpansion round function, and serves them to the
// cipher datapath through a registered random-access read port.
//
// Optional build macro: KEYSCHED_ZEROIZE_EN (adds the zeroize key-wipe input).
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   key_valid      cipher key presented on key_in (held until accepted)
//   key_in[127:0]  cipher key, word0 = [127:96]
//   key_ready      new key can be accepted (state != EXPAND)
//   busy           expansion in progress (state == EXPAND)
//   keys_valid     all 11 round keys stored and stable
//   rd_en, rd_idx  round-key read request and index 0..10
//   rd_data        registered round key
//   rd_vld         1-cycle pulse: rd_data holds the requested key
//   rd_err         1-cycle pulse: read rejected (no keys or index > 10)
//   zeroize        key wipe request (KEYSCHED_ZEROIZE_EN builds only)

module keyExpansion (
  input  logic [127:0] key_in,
  input  logic [3:0]   round_i,
  output logic [127:0] key_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (a^254, with 0 -> 0) followed by the
  // affine transform, so no 256-entry table is needed.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = key_in[127:96];
  assign w_w1 = key_in[95:64];
  assign w_w2 = key_in[63:32];
  assign w_w3 = key_in[31:0];

  // SubWord(RotWord(w3)) ^ Rcon
  assign w_temp = {sbox(w_w3[23:16]) ^ rcon(round_i), sbox(w_w3[15:8]),
                   sbox(w_w3[7:0]), sbox(w_w3[31:24])};

  assign w_n0 = w_w0 ^ w_temp;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign key_out = {w_n0, w_n1, w_n2, w_n3};

endmodule

module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [127:0]     key_in,
  output logic             key_ready,
  output logic             busy,
  output logic             keys_valid,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [127:0]     rd_data,
  output logic             rd_vld,
`ifdef KEYSCHED_ZEROIZE_EN
  output logic             rd_err,
  input  logic             zeroize
`else
  output logic             rd_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

  state_t           r_state;
  logic [IDX_W-1:0] r_rnd;
  logic [127:0]     r_work;
  logic [127:0]     r_rk [0:NUM_ROUNDS];
  logic             r_keys_valid;
  logic [127:0]     r_rd_data;
  logic             r_rd_vld;
  logic             r_rd_err;

  logic [127:0]     w_ke_out;
  logic             w_zeroize;
  logic             w_rd_ok;

`ifdef KEYSCHED_ZEROIZE_EN
  assign w_zeroize = zeroize;
`else
  assign w_zeroize = 1'b0;
`endif

  keyExpansion u_key_expansion (
    .key_in  (r_work),
    .round_i (r_rnd),
    .key_out (w_ke_out)
  );

  // Reads see the pre-edge keys_valid, so a read on the accept edge still
  // returns the old schedule; a zeroize on the same edge forces the error path.
  assign w_rd_ok = r_keys_valid && !w_zeroize && (rd_idx <= LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rnd        <= '0;
      r_work       <= '0;
      r_keys_valid <= 1'b0;
      r_rd_data    <= '0;
      r_rd_vld     <= 1'b0;
      r_rd_err     <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) r_rk[i] <= '0;
    end else begin
      r_rd_vld <= 1'b0;
      r_rd_err <= 1'b0;
      if (rd_en) begin
        if (w_rd_ok) begin
          r_rd_data <= r_rk[rd_idx];
          r_rd_vld  <= 1'b1;
        end else begin
          r_rd_data <= '0;
          r_rd_err  <= 1'b1;
        end
      end

      if (w_zeroize) begin
        r_state      <= ST_IDLE;
        r_rnd        <= '0;
        r_work       <= '0;
        r_keys_valid <= 1'b0;
        for (int i = 0; i <= NUM_ROUNDS; i++) r_rk[i] <= '0;
      end else begin
        case (r_state)
          ST_IDLE, ST_READY: begin
            if (key_valid) begin
              r_rk[0]      <= key_in;
              r_work       <= key_in;
              r_rnd        <= IDX_W'(1);
              r_keys_valid <= 1'b0;
              r_state      <= ST_EXPAND;
            end
          end
          ST_EXPAND: begin
            r_rk[r_rnd] <= w_ke_out;
            r_work      <= w_ke_out;
            if (r_rnd == LAST_IDX) begin
              r_rnd        <= '0;
              r_keys_valid <= 1'b1;
              r_state      <= ST_READY;
            end else begin
              r_rnd <= r_rnd + IDX_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign key_ready  = (r_state != ST_EXPAND);
  assign busy       = (r_state == ST_EXPAND);
  assign keys_valid = r_keys_valid;
  assign rd_data    = r_rd_data;
  assign rd_vld     = r_rd_vld;
  assign rd_err     = r_rd_err;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - directed self-checking bench for aes_key_sched_ctrl
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] K_FIPS     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_FIPS_RK10= 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_ZERO     = 128'h0;
  localparam logic [127:0] K_ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] K_ZERO_RK10= 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [127:0] rd_data;
  logic         rd_vld;
  logic         rd_err;
`ifdef KEYSCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.NUM_ROUNDS(10), .IDX_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .rd_vld     (rd_vld),
`ifdef KEYSCHED_ZEROIZE_EN
    .rd_err     (rd_err),
    .zeroize    (zeroize)
`else
    .rd_err     (rd_err)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One read: request before an edge, observe after it.
  task automatic do_read(input string tag, input logic [3:0] idx, input logic exp_vld,
                         input logic exp_err, input logic [127:0] exp_data);
    rd_en  = 1'b1;
    rd_idx = idx;
    step();
    rd_en  = 1'b0;
    chk({tag, "_vld"}, 128'(rd_vld), 128'(exp_vld));
    chk({tag, "_err"}, 128'(rd_err), 128'(exp_err));
    chk({tag, "_data"}, rd_data, exp_data);
  endtask

  // Accept a key (key_valid held for exactly the accept edge) and check the
  // 10-cycle expansion window.
  task automatic load_key(input string tag, input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    chk({tag, "_busy_after_accept"}, 128'(busy), 128'(1));
    for (int i = 0; i < 9; i++) begin
      step();
      chk({tag, "_kv_low_window"}, 128'({key_ready, keys_valid}), 128'(2'b00));
    end
    step();
    chk({tag, "_kv_at_accept_plus10"}, 128'({keys_valid, key_ready, busy}), 128'(3'b110));
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rd_en     = 1'b0;
    rd_idx    = '0;
`ifdef KEYSCHED_ZEROIZE_EN
    zeroize   = 1'b0;
`endif
    step();
    step();
    chk("reset_ctrl", 128'({key_ready, busy, keys_valid, rd_vld, rd_err}), 128'(5'b10000));
    chk("reset_rd_data", rd_data, '0);
    rst_n = 1'b1;
    step();

    // FIPS-197 key schedule
    load_key("fips", K_FIPS);
    do_read("fips_rk1", 4'd1, 1'b1, 1'b0, K_FIPS_RK1);
    do_read("fips_rk10", 4'd10, 1'b1, 1'b0, K_FIPS_RK10);
    do_read("fips_rk0", 4'd0, 1'b1, 1'b0, K_FIPS);
    step();
    chk("idle_rd_hold", rd_data, K_FIPS);
    chk("idle_rd_pulses", 128'({rd_vld, rd_err}), 128'(2'b00));

    // Out-of-range indices while keys are valid
    do_read("idx11", 4'd11, 1'b0, 1'b1, '0);
    do_read("idx15", 4'd15, 1'b0, 1'b1, '0);

    // All-zero key, accepted from READY; read during EXPAND must fail
    key_in    = K_ZERO;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    chk("zero_accept_kv_drop", 128'(keys_valid), 128'(0));
    do_read("rd_during_expand", 4'd0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 9; i++) step();
    chk("zero_kv_rise", 128'(keys_valid), 128'(1));

    // Back-to-back reads 0..10
    for (int i = 0; i <= 10; i++) begin
      rd_en  = 1'b1;
      rd_idx = 4'(i);
      step();
      chk("b2b_vld", 128'({rd_vld, rd_err}), 128'(2'b10));
      if (i == 0)  chk("b2b_rk0", rd_data, K_ZERO);
      if (i == 1)  chk("b2b_rk1", rd_data, K_ZERO_RK1);
      if (i == 10) chk("b2b_rk10", rd_data, K_ZERO_RK10);
    end
    rd_en = 1'b0;
    step();
    chk("b2b_end_vld", 128'(rd_vld), 128'(0));
    chk("b2b_end_hold", rd_data, K_ZERO_RK10);

    // Second key held during EXPAND: accepted only at the READY edge,
    // with a same-edge read returning the first key's schedule.
    key_in    = K_FIPS;
    key_valid = 1'b1;
    step();
    key_in = K_ZERO;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("hold_no_early_accept", 128'({busy, keys_valid}), 128'(2'b10));
    end
    step();
    chk("hold_ready_edge", 128'({keys_valid, key_ready}), 128'(2'b11));
    rd_en  = 1'b1;
    rd_idx = 4'd1;
    step();
    rd_en     = 1'b0;
    key_valid = 1'b0;
    chk("second_accept_kv", 128'({keys_valid, busy}), 128'(2'b01));
    chk("same_edge_read_vld", 128'(rd_vld), 128'(1));
    chk("same_edge_read_old", rd_data, K_FIPS_RK1);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("second_kv_low", 128'(keys_valid), 128'(0));
    end
    step();
    chk("second_kv_rise", 128'(keys_valid), 128'(1));
    do_read("second_rk1", 4'd1, 1'b1, 1'b0, K_ZERO_RK1);
    do_read("second_rk10", 4'd10, 1'b1, 1'b0, K_ZERO_RK10);

    // Reset mid-expansion (rnd=5)
    key_in    = K_FIPS;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 128'({key_ready, busy, keys_valid, rd_vld, rd_err}), 128'(5'b10000));
    chk("midrst_rd_data", rd_data, '0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("midrst_no_kv", 128'({keys_valid, busy}), 128'(2'b00));
    end
    do_read("midrst_read", 4'd0, 1'b0, 1'b1, '0);

`ifdef KEYSCHED_ZEROIZE_EN
    load_key("zq", K_FIPS);
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    chk("zeroize_kv", 128'({keys_valid, key_ready}), 128'(2'b01));
    do_read("zeroize_read", 4'd1, 1'b0, 1'b1, '0);
    load_key("zq2", K_ZERO);
    do_read("zq2_rk10", 4'd10, 1'b1, 1'b0, K_ZERO_RK10);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequences the existing combinational keyExpansion module to produce the full AES-128 key schedule: round keys 0..10, one round per clock.
- Stores all 11 round keys in an internal register file.
- Exposes a valid/ready key-load handshake and a registered random-access read port for the cipher round datapath.
- Sits between the key source (testbench/host) and the AES round controller.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; fixed for AES-128, values other than 10 unsupported.
- IDX_W, 4, width of the round-key index.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- key_valid  input  1  cipher key presented on key_in
- key_in  input  128  cipher key; word0 = [127:96]
- key_ready  output  1  block can accept a new key
- busy  output  1  expansion in progress
- keys_valid  output  1  all 11 round keys stored and stable
- rd_en  input  1  round-key read request
- rd_idx  input  IDX_W  round-key index, 0..10
- rd_data  output  128  round key, registered
- rd_vld  output  1  rd_data valid; 1-cycle pulse per read
- rd_err  output  1  read rejected; 1-cycle pulse
- zeroize  input  1  key wipe request; only present with KEYSCHED_ZEROIZE_EN

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, round counter=0, working key=0, all rk[0..10]=0.
  - key_ready=1, busy=0, keys_valid=0, rd_data=0, rd_vld=0, rd_err=0.
- FSM states: IDLE, EXPAND, READY.
- Accept: the edge where key_valid & key_ready, legal in IDLE or READY.
  - rk[0]<=key_in, work<=key_in, rnd<=1, keys_valid<=0, state<=EXPAND.
- EXPAND:
  - keyExpansion is driven with key_in=work, round_i=rnd.
  - Each cycle: rk[rnd]<=ke_out, work<=ke_out, rnd<=rnd+1.
  - When rnd==10: write rk[10], rnd<=0, keys_valid<=1, state<=READY.
- Latency: keys_valid rises exactly 10 cycles after the accept edge.
- Output decode: key_ready=(state!=EXPAND), busy=(state==EXPAND). Both are decoded from state, so they have no extra register delay.
- key_valid during EXPAND: ignored, no change to progress. The source must hold key_valid until accepted.
- New key accepted in READY: keys_valid drops on that same edge. Old keys are overwritten progressively.
- Reads, registered, 1-cycle latency:
  - rd_en & keys_valid & rd_idx<=10: next cycle rd_data=rk[rd_idx], rd_vld=1, rd_err=0.
  - rd_en & (!keys_valid | rd_idx>10): next cycle rd_data=0, rd_vld=0, rd_err=1.
  - No rd_en: rd_vld=0, rd_err=0, rd_data holds its last value.
- Read and accept on the same edge: the read is evaluated with pre-edge keys_valid, so it succeeds and returns the old rk.
- rnd is 4-bit and never exceeds 10. The index is compared unsigned, so 11..15 are errors.
- Reset mid-EXPAND: immediate return to the reset state. Partial keys are cleared and no keys_valid pulse is produced.

Optional Feature:
- Macro KEYSCHED_ZEROIZE_EN.
- When defined, the zeroize input port exists. A zeroize sample high on an edge:
  - clears all rk, work and rnd to 0;
  - forces state=IDLE and keys_valid=0;
  - takes priority over accept and over EXPAND progress.
  - A read in that cycle returns the rd_err path on the next cycle.
- When undefined: no zeroize port; keys persist until reset or the next accepted key.

Test Plan:
- Reset then present key 2b7e151628aed2a6abf7158809cf4f3c for one cycle -> key_ready low for 10 cycles. keys_valid rises at accept+10.
  - rd_idx=1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_idx=0 -> the original key.
- All-zero key, read indices 0..10 back-to-back:
  - rd_idx=1 -> 62636363626363636263636362636363.
  - rd_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
  - rd_vld high on every cycle following a rd_en.
- rd_en with rd_idx=11 and with rd_idx=15 while keys_valid -> rd_err pulse, rd_data=0. rd_en during EXPAND -> rd_err.
- Hold key_valid high with a second key during EXPAND -> second key accepted only at the READY edge. keys_valid low for the following 10 cycles, then the schedule of the second key.
- Drop rst_n at EXPAND rnd=5 -> all outputs return to reset values immediately. Reading after re-reset gives rd_err.
- With KEYSCHED_ZEROIZE_EN defined: zeroize in READY -> keys_valid=0 next cycle. A subsequent read gives rd_err; a new key then expands normally.
